// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - oversampling UART receiver with parity, stop-bit, overrun checking
// Optional break reporting is enabled by defining UART_RX_BREAK_DETECT_EN.
module uart_receiver #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  overSampleTick,
  input  logic                  rx,
  input  logic [4:0]            overSampling,
  input  logic [3:0]            dataType,
  input  logic                  parityEnable,
  input  logic                  parityType,
  input  logic [1:0]            stopBits,
  output logic [DATA_WIDTH-1:0] rxData,
  output logic                  rxValid,
  input  logic                  rxReady,
  output logic                  parityError,
  output logic                  framingError,
  output logic                  breakError,
  output logic                  overrunError,
  output logic                  busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;
  localparam logic [3:0] DW4     = 4'(DATA_WIDTH);
`ifdef UART_RX_BREAK_DETECT_EN
  localparam logic BRK_EN = 1'b1;
`else
  localparam logic BRK_EN = 1'b0;
`endif

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s, mid, last, complete;
  logic [3:0]             bits_cfg;
  logic [DATA_WIDTH-1:0]  rx_vec;

  logic [2:0]            state_q, state_d;
  logic [4:0]            tick_q, tick_d, os_q, os_d;
  logic [3:0]            bit_q, bit_d, nbits_q, nbits_d;
  logic                  pen_q, pen_d, ptype_q, ptype_d, stop2_q, stop2_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, data_q, data_d;
  logic                  par_q, par_d, zero_q, zero_d, ferr_q, ferr_d, perr_q, perr_d, brk_q, brk_d;
  logic                  valid_q, valid_d, pe_q, pe_d, fe_q, fe_d, be_q, be_d, ov_q, ov_d;

  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign rx_vec   = {{(DATA_WIDTH-1){1'b0}}, rx_s};
  assign mid      = (tick_q == {1'b0, os_q[4:1]});
  assign last     = (tick_q == os_q - 5'd1);
  assign bits_cfg = (dataType < 4'd5 || dataType > DW4) ? DW4 : dataType;

  always_comb begin
    state_d = state_q;  tick_d  = tick_q;  bit_d   = bit_q;
    os_d    = os_q;     nbits_d = nbits_q; pen_d   = pen_q;
    ptype_d = ptype_q;  stop2_d = stop2_q; shift_d = shift_q;
    par_d   = par_q;    zero_d  = zero_q;  ferr_d  = ferr_q;
    perr_d  = perr_q;   brk_d   = brk_q;   data_d  = data_q;
    valid_d = valid_q;  pe_d    = pe_q;    fe_d    = fe_q;
    be_d    = be_q;     ov_d    = ov_q;    complete = 1'b0;

    if (state_q == S_IDLE) begin
      os_d    = overSampling;
      nbits_d = bits_cfg;
      pen_d   = parityEnable;
      ptype_d = parityType;
      stop2_d = (stopBits == 2'd2);
    end

    if (overSampleTick) begin
      tick_d = last ? 5'd0 : tick_q + 5'd1;
      case (state_q)
        S_IDLE: begin
          tick_d = 5'd0;
          bit_d  = 4'd0;
          if (!rx_s) begin
            state_d = S_START;
            shift_d = '0;
            par_d   = 1'b0;
            zero_d  = 1'b1;
            ferr_d  = 1'b0;
            perr_d  = 1'b0;
            brk_d   = 1'b0;
          end
        end
        S_START: begin
          if (mid && rx_s) begin
            state_d = S_IDLE;
            tick_d  = 5'd0;
          end else if (last) begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          if (mid) begin
            shift_d = shift_q | (rx_vec << bit_q);
            par_d   = par_q ^ rx_s;
            if (rx_s) zero_d = 1'b0;
          end
          if (last) begin
            if (bit_q == nbits_q - 4'd1) begin
              bit_d   = 4'd0;
              state_d = pen_q ? S_PAR : S_STOP;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
        end
        S_PAR: begin
          if (mid) begin
            perr_d = ((par_q ^ rx_s) != ptype_q);
            if (rx_s) zero_d = 1'b0;
          end
          if (last) state_d = S_STOP;
        end
        S_STOP: begin
          // Completion fires on the mid-sample of the final stop bit, not at its end.
          if (mid) begin
            if (!rx_s) ferr_d = 1'b1;
            if (bit_q == 4'd0) brk_d = zero_q & ~rx_s;
            if (bit_q == {3'd0, stop2_q}) begin
              complete = 1'b1;
              tick_d   = 5'd0;
              bit_d    = 4'd0;
              state_d  = rx_s ? S_IDLE : S_WAIT;
            end
          end
          if (last && !complete) bit_d = bit_q + 4'd1;
        end
        S_WAIT: begin
          tick_d = 5'd0;
          if (rx_s) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (complete) begin
      if (valid_q && !rxReady) begin
        ov_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        ov_d    = 1'b0;
        data_d  = shift_d;
        pe_d    = perr_d;
        fe_d    = ferr_d;
        be_d    = BRK_EN & brk_d;
        if (be_d) begin
          fe_d   = 1'b0;
          data_d = '0;
        end
      end
    end else if (valid_q && rxReady) begin
      valid_d = 1'b0;
      pe_d    = 1'b0;
      fe_d    = 1'b0;
      be_d    = 1'b0;
      ov_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '1;
      state_q <= S_IDLE;  tick_q  <= 5'd0;  bit_q   <= 4'd0;
      os_q    <= 5'd16;   nbits_q <= DW4;   pen_q   <= 1'b0;
      ptype_q <= 1'b0;    stop2_q <= 1'b0;  shift_q <= '0;
      par_q   <= 1'b0;    zero_q  <= 1'b0;  ferr_q  <= 1'b0;
      perr_q  <= 1'b0;    brk_q   <= 1'b0;  data_q  <= '0;
      valid_q <= 1'b0;    pe_q    <= 1'b0;  fe_q    <= 1'b0;
      be_q    <= 1'b0;    ov_q    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rx};
      state_q <= state_d; tick_q  <= tick_d;  bit_q   <= bit_d;
      os_q    <= os_d;    nbits_q <= nbits_d; pen_q   <= pen_d;
      ptype_q <= ptype_d; stop2_q <= stop2_d; shift_q <= shift_d;
      par_q   <= par_d;   zero_q  <= zero_d;  ferr_q  <= ferr_d;
      perr_q  <= perr_d;  brk_q   <= brk_d;   data_q  <= data_d;
      valid_q <= valid_d; pe_q    <= pe_d;    fe_q    <= fe_d;
      be_q    <= be_d;    ov_q    <= ov_d;
    end
  end

  assign rxData       = data_q;
  assign rxValid      = valid_q;
  assign parityError  = pe_q;
  assign framingError = fe_q;
  assign breakError   = be_q;
  assign overrunError = ov_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, maximum data bits per frame and width of rxData.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of flops in the rx input synchronizer (minimum 2).
REQ-003 SHALL have ports: clk input 1, the single clock; reset input 1, asynchronous active-high reset.
REQ-004 SHALL have ports: overSampleTick input 1, one-cycle pulse at baud x oversampling rate; rx input 1, serial line, idle high.
REQ-005 SHALL have config ports: overSampling input 5 (16 or 13); dataType input 4 (5..8); parityEnable input 1; parityType input 1 (0 even, 1 odd); stopBits input 2 (1 or 2).
REQ-006 SHALL have ports: rxData output DATA_WIDTH; rxValid output 1; rxReady input 1; parityError, framingError, breakError, overrunError output 1 each; busy output 1.

Function
REQ-007 SHALL pass rx through SYNC_STAGES flops, reset value 1; all sampling uses the synchronized value.
REQ-008 SHALL run FSM states IDLE, STARTBIT, DATABITS, PARITYBIT, STOPBIT, WAITIDLE; the tick counter and bit counter advance only on overSampleTick.
REQ-009 IDLE -> STARTBIT on the first tick where synchronized rx = 0; tick counter cleared.
REQ-010 SHALL sample each bit at tick count overSampling/2 (8 for 16, 6 for 13) counted from the bit's start; each bit lasts overSampling ticks.
REQ-011 STARTBIT: rx = 1 at mid-sample -> IDLE (glitch rejected, no output); rx = 0 -> DATABITS at bit end.
REQ-012 DATABITS SHALL shift in LSB first; after dataType bits go to PARITYBIT if parityEnable, else STOPBIT; unused upper rxData bits are 0.
REQ-013 PARITYBIT: parityError = (XOR of data bits XOR parity bit) != parityType.
REQ-014 STOPBIT SHALL check stopBits stop bits; any stop sample 0 sets framingError.
REQ-015 Frame completion occurs in the cycle after the last stop-bit mid-sample; latency = 1 clk from that tick. The FSM returns to IDLE, or to WAITIDLE if the last stop sample was 0.
REQ-016 WAITIDLE -> IDLE on the first tick with rx = 1.
REQ-017 On completion with rxValid = 0, or rxValid = 1 with rxReady = 1 in the same cycle: load rxData and the error flags, set rxValid = 1, overrunError = 0.
REQ-018 On completion with rxValid = 1 and rxReady = 0: discard the new frame, keep held data, set overrunError = 1.
REQ-019 rxValid & rxReady without completion SHALL clear rxValid and all four error flags next cycle.
REQ-020 busy = 1 in every state except IDLE.
REQ-021 Config inputs SHALL be sampled only in IDLE and held for the frame; changes mid-frame have no effect.
REQ-022 dataType outside 5..DATA_WIDTH SHALL be treated as DATA_WIDTH.

Reset
REQ-023 On reset SHALL force: FSM IDLE, counters 0, synchronizer 1, rxData 0, rxValid 0, all error flags 0, busy 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame without output; after release, reception resumes at the next falling edge.

Configuration
REQ-025 Macro UART_RX_BREAK_DETECT_EN: when defined, a frame with all data bits, the parity bit (if enabled) and the first stop bit sampled 0 SHALL report breakError = 1, framingError = 0, rxData = 0.
REQ-026 Without UART_RX_BREAK_DETECT_EN, breakError SHALL be tied 0 and such a frame SHALL report framingError = 1.

Verification
REQ-027 16x, 8N1, rx frame 0xA5, rxReady = 1 -> one rxValid pulse, rxData = 0xA5, all errors 0.
REQ-028 13x, 7 bits, even parity, 2 stop bits, data 0x35 sent with wrong parity bit 1 -> rxData = 0x35, parityError = 1.
REQ-029 8N1, second frame 0x3C completes while 0x11 is held and rxReady = 0 -> rxData stays 0x11, overrunError = 1; pop clears both.
REQ-030 rx low for 5 ticks then high (16x) -> no rxValid, FSM back in IDLE; next valid frame 0x0F received correctly.
REQ-031 rx held low for 12 bit times, 8N1 -> with macro: breakError = 1, rxData = 0x00; without macro: framingError = 1; no new frame until rx returns high.
REQ-032 reset pulsed during bit 3 of a frame -> outputs at reset values, no rxValid; next frame 0x81 received correctly.
